mat_operand_tx: RTL and testbench
=================================

MAT_OPERAND_TX -- requirements
Module: mat_operand_tx

Interface
REQ-001 SHALL have parameter ELEM_W, default 4: operand element width in bits.
REQ-002 SHALL have parameter DIM, default 2: matrix dimension; only DIM=2 is supported.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an operand pair is presented.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts an operand pair this cycle.
REQ-007 SHALL have port in_mat_a, input, 16 bits: matrix A, row-major packing; A00=[3:0], A01=[7:4], A10=[11:8], A11=[15:12].
REQ-008 SHALL have port in_mat_b, input, 16 bits: matrix B, same packing as in_mat_a.
REQ-009 SHALL have port mat1, output, 8 bits: current A row, packed as {A[i][1],A[i][0]}.
REQ-010 SHALL have port mat2, output, 4 bits: current B element B[k][j].
REQ-011 SHALL have port out_valid, output, 1 bit: mat1/mat2 hold a valid beat.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream multiplier accepts the current beat.
REQ-013 SHALL have port out_first, output, 1 bit: marks beat 0 of a transfer.
REQ-014 SHALL have port out_last, output, 1 bit: marks beat 7 of a transfer.
REQ-015 SHALL have port busy, output, 1 bit: high while in SEND.

Function
REQ-016 SHALL sequence two states: IDLE and SEND.
REQ-017 SHALL drive in_ready=1 in IDLE, and in SEND only when out_valid & out_ready & out_last; it SHALL be 0 otherwise.
REQ-018 SHALL, on in_valid & in_ready, register both matrices, clear the beat counter, and enter or stay in SEND on the next cycle.
REQ-019 SHALL emit 8 beats per transfer with beat index b = {i,j,k} (3 bits; i is the MSB, k the LSB, so k varies fastest).
REQ-020 SHALL drive mat1 = {A[i][1],A[i][0]} and mat2 = B[k][j] for each beat, computed from the registered copies only.
REQ-021 SHALL assert out_valid throughout SEND.
REQ-022 SHALL advance a beat only when out_valid & out_ready.
REQ-023 SHALL hold mat1, mat2, out_first and out_last stable while out_valid & !out_ready.
REQ-024 SHALL decode out_first = (b==0) and out_last = (b==7), both gated by out_valid.
REQ-025 SHALL return to IDLE after the last beat is accepted with no new operands accepted in that cycle; it SHALL then drive out_valid=0, mat1=0 and mat2=0.
REQ-026 SHALL, on a back-to-back transfer (last beat accepted and in_valid in the same cycle), present beat 0 of the new pair on the next cycle with no bubble.
REQ-027 SHALL ignore changes on in_mat_a and in_mat_b during SEND.
REQ-028 SHALL tolerate in_valid held high with no loss or duplication of transfers.

Reset
REQ-029 SHALL, while reset=1 at a clock edge, set state=IDLE, beat counter=0, registered matrices=0, mat1=0, mat2=0, out_valid=0 and busy=0.
REQ-030 SHALL force in_ready=0 while reset=1.
REQ-031 SHALL abort an in-flight transfer on reset mid-SEND and emit no further beats of it.
REQ-032 SHALL accept a new transfer in the first cycle after reset deasserts.

Structure
REQ-033 SHALL take ELEM_W, DIM, BEATS=8, the state encoding and the packed-field offsets from a shared package, mat_pkg.
REQ-034 SHALL instantiate one sub-module, mat_elem_sel, which selects a 4-bit element from a 16-bit packed matrix by row and column index (combinational).

Verification
REQ-035 SHALL cover: reset, then in_mat_a=16'h1001, in_mat_b=16'h4321, out_ready=1 -> mat2 sequence 1,3,2,4,1,3,2,4; mat1=8'h01 on beats 0-3 and 8'h10 on beats 4-7; out_first on beat 0 only, out_last on beat 7 only.
REQ-036 SHALL cover: the same stimulus with out_ready low on beats 2 and 5 for 3 cycles each -> outputs held, total 14 valid cycles, beat sequence unchanged.
REQ-037 SHALL cover: in_valid held high with a second pair (A=16'hFFFF, B=16'h0000) -> second transfer's beat 0 (mat1=8'hFF, mat2=0) appears in the cycle after the first transfer's beat 7, and in_ready pulses exactly once per transfer.
REQ-038 SHALL cover: reset asserted during beat 4 -> out_valid=0 in the next cycle, no further beats, in_ready=1 after release.
REQ-039 SHALL cover: in_mat_a toggled during SEND -> emitted beats reflect only the captured values.

Source files
------------

// File: rtl/mat_pkg.sv
// Shared constants, state encoding and packed-field helpers for the
// 2x2 matrix operand transmitter.
package mat_pkg;

  localparam int ELEM_W = 4;
  localparam int DIM    = 2;
  localparam int BEATS  = 8;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int MAT_W  = DIM * DIM * ELEM_W;
  localparam int ROW_W  = DIM * ELEM_W;

  // Row-major packing: element [r][c] lives at bit offset (r*DIM + c)*ELEM_W.
  localparam int OFF_00 = 0;
  localparam int OFF_01 = ELEM_W;
  localparam int OFF_10 = 2 * ELEM_W;
  localparam int OFF_11 = 3 * ELEM_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Bit offset of element [row][col] inside a packed row-major matrix.
  function automatic int elem_off(input int row, input int col,
                                  input int dim, input int elem_w);
    return (row * dim + col) * elem_w;
  endfunction

endpackage

// File: rtl/mat_elem_sel.sv
// Combinational selector: picks element [row][col] out of a packed
// row-major square matrix.
module mat_elem_sel
  import mat_pkg::*;
#(
  parameter int ELEM_W = mat_pkg::ELEM_W,
  parameter int DIM    = mat_pkg::DIM,
  localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic [DIM*DIM*ELEM_W-1:0] mat,
  input  logic [IDX_W-1:0]          row,
  input  logic [IDX_W-1:0]          col,
  output logic [ELEM_W-1:0]         elem
);

  // Full decode over all (row, col) pairs; out-of-range indices yield zero.
  always_comb begin
    elem = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        if (int'(row) == r && int'(col) == c) begin
          elem = mat[elem_off(r, c, DIM, ELEM_W) +: ELEM_W];
        end
      end
    end
  end

endmodule

// File: rtl/mat_operand_tx.sv
// Matrix operand transmitter: captures a 2x2 A/B operand pair and streams
// eight beats {i,j,k} to a downstream multiplier, each beat carrying row
// A[i] and element B[k][j]. Only DIM=2 is supported.
module mat_operand_tx
  import mat_pkg::*;
#(
  parameter int ELEM_W = mat_pkg::ELEM_W,
  parameter int DIM    = mat_pkg::DIM
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIM*DIM*ELEM_W-1:0] in_mat_a,
  input  logic [DIM*DIM*ELEM_W-1:0] in_mat_b,
  output logic [DIM*ELEM_W-1:0]     mat1,
  output logic [ELEM_W-1:0]         mat2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_first,
  output logic                      out_last,
  output logic                      busy
);

  localparam int MW    = DIM * DIM * ELEM_W;
  localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_p0, beat_d;
  logic [MW-1:0]       mat_a_p0, mat_a_d;
  logic [MW-1:0]       mat_b_p0, mat_b_d;
  logic                vld_p0;
  logic                fire;
  logic                is_last;
  logic                accept;
  logic [ELEM_W-1:0]   a_lo, a_hi, b_el;

  // Beat index b = {i, j, k}: k is the fastest-varying bit.
  logic [IDX_W-1:0] idx_i, idx_j, idx_k;
  assign idx_i = beat_p0[2];
  assign idx_j = beat_p0[1];
  assign idx_k = beat_p0[0];

  // ---- stage p0 -> output: element selection from the captured operands
  mat_elem_sel #(.ELEM_W(ELEM_W), .DIM(DIM)) u_sel_a_lo (
    .mat  (mat_a_p0),
    .row  (idx_i),
    .col  (IDX_W'(0)),
    .elem (a_lo)
  );

  mat_elem_sel #(.ELEM_W(ELEM_W), .DIM(DIM)) u_sel_a_hi (
    .mat  (mat_a_p0),
    .row  (idx_i),
    .col  (IDX_W'(1)),
    .elem (a_hi)
  );

  mat_elem_sel #(.ELEM_W(ELEM_W), .DIM(DIM)) u_sel_b (
    .mat  (mat_b_p0),
    .row  (idx_k),
    .col  (idx_j),
    .elem (b_el)
  );

  // Data outputs are forced to zero whenever no beat is being presented.
  assign mat1 = vld_p0 ? {a_hi, a_lo} : '0;
  assign mat2 = vld_p0 ? b_el : '0;

  // Next-state, handshake and beat-sequencing logic.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_p0;
    mat_a_d   = mat_a_p0;
    mat_b_d   = mat_b_p0;
    vld_p0    = (state_q == ST_SEND);
    out_valid = vld_p0;
    busy      = vld_p0;
    fire      = vld_p0 & out_ready;
    is_last   = (beat_p0 == BEAT_W'(BEATS - 1));
    out_first = vld_p0 & (beat_p0 == '0);
    out_last  = vld_p0 & is_last;
    // New operands are taken when idle, or on the cycle the final beat
    // leaves so that back-to-back transfers have no bubble.
    in_ready  = !reset && ((state_q == ST_IDLE) || (fire && is_last));
    accept    = in_valid & in_ready;

    if (fire) begin
      if (is_last) begin
        state_d = ST_IDLE;
      end else begin
        beat_d = beat_p0 + BEAT_W'(1);
      end
    end

    if (accept) begin
      mat_a_d = in_mat_a;
      mat_b_d = in_mat_b;
      beat_d  = '0;
      state_d = ST_SEND;
    end
  end

  // ---- stage in -> p0: state, beat counter and captured operands
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      beat_p0  <= '0;
      mat_a_p0 <= '0;
      mat_b_p0 <= '0;
    end else begin
      state_q  <= state_d;
      beat_p0  <= beat_d;
      mat_a_p0 <= mat_a_d;
      mat_b_p0 <= mat_b_d;
    end
  end

endmodule

// File: tb/tb_mat_operand_tx.sv
// Scoreboard bench for mat_operand_tx: drivers push hand-computed beats
// into a queue; a negedge monitor compares every presented beat.
module tb_mat_operand_tx;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_mat_a;
  logic [15:0] in_mat_b;
  logic [7:0]  mat1;
  logic [3:0]  mat2;
  logic        out_valid;
  logic        out_ready;
  logic        out_first;
  logic        out_last;
  logic        busy;

  typedef struct packed {
    logic [7:0] m1;
    logic [3:0] m2;
    logic       f;
    logic       l;
  } beat_t;

  beat_t q[$];
  int    checks      = 0;
  int    errors      = 0;
  int    vld_cycles  = 0;
  int    accepts     = 0;
  logic  b2b_pending = 1'b0;

  mat_operand_tx #(.ELEM_W(4), .DIM(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mat_a  (in_mat_a),
    .in_mat_b  (in_mat_b),
    .mat1      (mat1),
    .mat2      (mat2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_first (out_first),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Hand table for A=16'h1001, B=16'h4321: mat1 = 01 then 10, mat2 = 1,3,2,4 repeated.
  function automatic beat_t ref_beat(input int bi);
    beat_t  e;
    e.m1 = (bi < 4) ? 8'h01 : 8'h10;
    case (bi % 4)
      0:       e.m2 = 4'h1;
      1:       e.m2 = 4'h3;
      2:       e.m2 = 4'h2;
      default: e.m2 = 4'h4;
    endcase
    e.f = (bi == 0);
    e.l = (bi == 7);
    return e;
  endfunction

  task automatic push_ref(input int n);
    for (int bi = 0; bi < n; bi++) q.push_back(ref_beat(bi));
  endtask

  // A=16'hFFFF, B=16'h0000: every beat is mat1=FF, mat2=0.
  task automatic push_ff();
    beat_t e;
    for (int bi = 0; bi < 8; bi++) begin
      e.m1 = 8'hFF;
      e.m2 = 4'h0;
      e.f  = (bi == 0);
      e.l  = (bi == 7);
      q.push_back(e);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int n;
    in_valid = 1'b1;
    in_mat_a = a;
    in_mat_b = b;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
  endtask

  // Monitor: compares each presented beat against the queue head and pops
  // on acceptance; also checks idle outputs and back-to-back continuity.
  always @(negedge clk) begin
    beat_t e;
    if (b2b_pending) check("b2b_no_bubble", {31'd0, out_valid & out_first}, 32'd1);
    b2b_pending = !reset && out_valid && out_ready && out_last && in_valid && in_ready;
    if (in_valid && in_ready) accepts++;
    if (out_valid) begin
      vld_cycles++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual=mat1_%0h_mat2_%0h required=no_beat", mat1, mat2);
      end else begin
        e = q[0];
        check("mat1", {24'd0, mat1}, {24'd0, e.m1});
        check("mat2", {28'd0, mat2}, {28'd0, e.m2});
        check("out_first", {31'd0, out_first}, {31'd0, e.f});
        check("out_last", {31'd0, out_last}, {31'd0, e.l});
        if (out_ready) void'(q.pop_front());
      end
    end else begin
      check("idle_outputs", {18'd0, mat1, mat2, out_first, out_last}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] pat;
    int          v0;
    int          a0;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_mat_a  = 16'h0;
    in_mat_b  = 16'h0;
    out_ready = 1'b1;

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data", {20'd0, mat1, mat2}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_init", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Basic transfer, out_ready held high
    push_ref(8);
    send(16'h1001, 16'h4321);
    wait_idle();
    check("queue_after_basic", q.size(), 32'd0);

    // Stalls on beats 2 and 5 for three cycles each: 14 valid cycles
    push_ref(8);
    v0  = vld_cycles;
    pat = 14'b11100011100011;
    send(16'h1001, 16'h4321);
    for (int t = 0; t < 14; t++) begin
      out_ready = pat[t];
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle();
    check("stall_valid_cycles", vld_cycles - v0, 32'd14);

    // Back-to-back with in_valid held high
    a0 = accepts;
    push_ref(8);
    push_ff();
    send(16'h1001, 16'h4321);
    send(16'hFFFF, 16'h0000);
    wait_idle();
    check("b2b_accepts", accepts - a0, 32'd2);
    check("queue_after_b2b", q.size(), 32'd0);

    // Reset during beat 4 aborts the transfer
    push_ref(5);
    send(16'h1001, 16'h4321);
    repeat (4) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk);
    check("rst_forces_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("queue_after_abort", q.size(), 32'd0);

    // Accept on the first cycle after release, then toggle in_mat_a mid-SEND
    @(posedge clk); #1;
    reset = 1'b0;
    push_ref(8);
    in_valid = 1'b1;
    in_mat_a = 16'h1001;
    in_mat_b = 16'h4321;
    @(negedge clk);
    check("ready_after_reset", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int t = 0; t < 10; t++) begin
      in_mat_a = (t % 2 == 0) ? 16'hABCD : 16'h5A5A;
      in_mat_b = (t % 2 == 0) ? 16'hFFFF : 16'h0F0F;
      @(posedge clk); #1;
    end
    wait_idle();
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("queue_final", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
